// File: rtl/oka_subproduct_seq_15bit.sv
// Bit-serial generator of the four even/odd half products for one OKA tier.
// Operands are split by coefficient parity and multiplied carry-lessly over n/2 cycles.
module oka_subproduct_seq_15bit #(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] a_in,
    input  logic [n-1:0] b_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-2:0] prod_ee,
    output logic [n-2:0] prod_eo,
    output logic [n-2:0] prod_oe,
    output logic [n-2:0] prod_oo
);

    localparam int H  = n / 2;
    localparam int PW = n - 1;
    localparam int CW = (H > 1) ? $clog2(H) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [PW-1:0] r_mcandE;
    logic [PW-1:0] r_mcandO;
    logic [H-1:0]  r_mulE;
    logic [H-1:0]  r_mulO;
    logic [PW-1:0] r_accEE;
    logic [PW-1:0] r_accEO;
    logic [PW-1:0] r_accOE;
    logic [PW-1:0] r_accOO;
    logic [CW-1:0] r_cnt;
    logic          r_inReady;
    logic          r_outValid;

    logic [PW-1:0] w_aEven;
    logic [PW-1:0] w_aOdd;
    logic [H-1:0]  w_bEven;
    logic [H-1:0]  w_bOdd;
    logic          w_accept;

    // Even/odd coefficient split; multiplicands are zero-extended to product width.
    always_comb begin
        w_aEven = '0;
        w_aOdd  = '0;
        w_bEven = '0;
        w_bOdd  = '0;
        for (int i = 0; i < H; i++) begin
            w_aEven[i] = a_in[2*i];
            w_aOdd[i]  = a_in[2*i+1];
            w_bEven[i] = b_in[2*i];
            w_bOdd[i]  = b_in[2*i+1];
        end
    end

    assign w_accept = in_valid && (r_state == S_IDLE);

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_nextState = S_RUN;
            S_RUN:   if (r_cnt == LAST_ITER) w_nextState = S_DONE;
            S_DONE:  if (out_ready) w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so no input reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_inReady  <= (w_nextState == S_IDLE);
            r_outValid <= (w_nextState == S_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcandE <= '0;
            r_mcandO <= '0;
            r_mulE   <= '0;
            r_mulO   <= '0;
            r_accEE  <= '0;
            r_accEO  <= '0;
            r_accOE  <= '0;
            r_accOO  <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mcandE <= w_aEven;
                        r_mcandO <= w_aOdd;
                        r_mulE   <= w_bEven;
                        r_mulO   <= w_bOdd;
                        r_accEE  <= '0;
                        r_accEO  <= '0;
                        r_accOE  <= '0;
                        r_accOO  <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    r_accEE  <= r_accEE ^ (r_mulE[0] ? r_mcandE : '0);
                    r_accEO  <= r_accEO ^ (r_mulO[0] ? r_mcandE : '0);
                    r_accOE  <= r_accOE ^ (r_mulE[0] ? r_mcandO : '0);
                    r_accOO  <= r_accOO ^ (r_mulO[0] ? r_mcandO : '0);
                    r_mcandE <= r_mcandE << 1;
                    r_mcandO <= r_mcandO << 1;
                    r_mulE   <= r_mulE >> 1;
                    r_mulO   <= r_mulO >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign prod_ee   = r_accEE;
    assign prod_eo   = r_accEO;
    assign prod_oe   = r_accOE;
    assign prod_oo   = r_accOO;

endmodule
